// File: rtl/lab_g_reg_arbiter.sv
// Two-requester round-robin arbiter owning a shared data register.
// A grant lasts one GRANT cycle plus HOLD_CYCLES HOLD cycles.
module lab_g_reg_arbiter #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] Q,
  output logic             owner,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    HOLD
  } state_t;

  localparam logic [3:0] HOLD_N = 4'(HOLD_CYCLES);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic             own_q, own_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sel_req;

  assign sel_req = sel_q ? req1 : req0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    own_d   = own_q;
    q_d     = q_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          (req0 && req1): begin
            sel_d   = ~last_q;
            state_d = GRANT;
          end
          (req0 && !req1): begin
            sel_d   = 1'b0;
            state_d = GRANT;
          end
          (!req0 && req1): begin
            sel_d   = 1'b1;
            state_d = GRANT;
          end
          default: state_d = IDLE;
        endcase
      end
      GRANT: begin
        if (sel_req) begin
          q_d     = sel_q ? d1 : d0;
          own_d   = sel_q;
          last_d  = sel_q;
          cnt_d   = 4'd1;
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_N) begin
          cnt_d   = 4'd0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Grant and busy follow the next state so they stay registered.
    busy_d = (state_d != IDLE);
    gnt0_d = busy_d && !sel_d;
    gnt1_d = busy_d && sel_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      q_q     <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      own_q   <= own_d;
      q_q     <= q_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign Q     = q_q;
  assign owner = own_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_lab_g_reg_arbiter.sv
// Scoreboard bench for lab_g_reg_arbiter: transaction model feeds a queue,
// a negedge monitor checks each grant episode against it.
module tb_lab_g_reg_arbiter;

  localparam int W = 8;
  localparam int H = 2;

  typedef struct {
    bit         commit;
    bit         idx;
    logic [W-1:0] data;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] d0, d1;
  logic         gnt0, gnt1;
  logic [W-1:0] Q;
  logic         owner, busy, done;

  int total = 0;
  int bad   = 0;

  exp_t         sb[$];
  exp_t         cur;
  bit           in_ep = 0;
  int           ep_len = 0;
  logic [W-1:0] mon_q = '0;
  bit           mon_own = 0;
  bit           last = 1;
  logic         g;

  lab_g_reg_arbiter #(.WIDTH(W), .HOLD_CYCLES(H)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .req1  (req1),
    .d0    (d0),
    .d1    (d1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .Q     (Q),
    .owner (owner),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               nm, a, e, $time);
    end
  endtask

  // One transaction, started at a negedge with the DUT about to
  // evaluate IDLE. mode 0: req0, 1: req1, 2: both.
  task automatic txn(input int mode,
                     input logic [W-1:0] a0,
                     input logic [W-1:0] a1,
                     input bit abort,
                     input bit rnd,
                     input logic [W-1:0] hd0,
                     input logic [W-1:0] hd1);
    exp_t e;
    bit   idx;
    idx = (mode == 2) ? !last : (mode == 1);
    e.commit = !abort;
    e.idx    = idx;
    e.data   = idx ? a1 : a0;
    sb.push_back(e);
    if (!abort) last = idx;
    req0 = (mode != 1);
    req1 = (mode != 0);
    d0 = a0;
    d1 = a1;
    @(negedge clk);
    if (abort) begin
      req0 = 0;
      req1 = 0;
      d0 = W'($urandom);
      d1 = W'($urandom);
    end else begin
      for (int i = 0; i < H; i++) begin
        @(negedge clk);
        if (rnd) begin
          req0 = 1'($urandom);
          req1 = 1'($urandom);
          d0 = W'($urandom);
          d1 = W'($urandom);
        end else begin
          d0 = hd0;
          d1 = hd1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req0 = 0;
    req1 = 0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        in_ep = 0;
        ep_len = 0;
        mon_q = '0;
        mon_own = 0;
        sb.delete();
      end else begin
        g = gnt0 | gnt1;
        chk("mutex", 32'(gnt0 & gnt1), 0);
        chk("busy", 32'(busy), 32'(g));
        if (in_ep) begin
          if (g) begin
            ep_len++;
            chk("gidx_hold", 32'(gnt1), 32'(cur.idx));
            if (cur.commit) begin
              chk("q_hold", 32'(Q), 32'(cur.data));
              chk("own_hold", 32'(owner), 32'(cur.idx));
            end else begin
              chk("q_abort", 32'(Q), 32'(mon_q));
            end
          end else begin
            in_ep = 0;
            chk("len", ep_len, cur.commit ? 1 + H : 1);
            chk("done", 32'(done), 32'(cur.commit));
            if (cur.commit) begin
              mon_q = cur.data;
              mon_own = cur.idx;
            end
            chk("q_end", 32'(Q), 32'(mon_q));
            chk("own_end", 32'(owner), 32'(mon_own));
          end
        end else if (g) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL grant: got unexpected grant want none t=%0t",
                     $time);
          end else begin
            cur = sb.pop_front();
            in_ep = 1;
            ep_len = 1;
            chk("gidx", 32'(gnt1), 32'(cur.idx));
            chk("q_grant", 32'(Q), 32'(mon_q));
          end
        end else begin
          chk("done_idle", 32'(done), 0);
          chk("q_idle", 32'(Q), 32'(mon_q));
          chk("own_idle", 32'(owner), 32'(mon_own));
        end
      end
    end
  end

  initial begin
    rst = 0;
    req0 = 0;
    req1 = 0;
    d0 = '0;
    d1 = '0;
    #1 rst = 1;
    #2;
    chk("rst_gnt", 32'({gnt0, gnt1}), 0);
    chk("rst_q", 32'(Q), 0);
    chk("rst_misc", 32'({owner, busy, done}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    last = 1;
    for (int i = 0; i < 4; i++)
      txn(2, 8'h11, 8'h22, 0, 0, 8'h11, 8'h22);
    idle(2);
    txn(0, 8'hA5, 8'h00, 0, 0, 8'hA5, 8'h00);
    idle(1);
    txn(1, 8'h00, 8'h3C, 1, 0, 8'h00, 8'h3C);
    idle(1);
    txn(0, 8'h0F, 8'h00, 0, 0, 8'hF0, 8'h00);
    txn(0, 8'hF0, 8'h00, 0, 0, 8'hF0, 8'h00);
    idle(1);
    req0 = 1;
    req1 = 0;
    d0 = 8'h77;
    cur.commit = 1;
    cur.idx = 0;
    cur.data = 8'h77;
    sb.push_back(cur);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1;
    req0 = 0;
    req1 = 0;
    #1;
    chk("arst_gnt", 32'({gnt0, gnt1}), 0);
    chk("arst_q", 32'(Q), 0);
    chk("arst_misc", 32'({owner, busy, done}), 0);
    #1 rst = 0;
    last = 1;
    @(negedge clk);
    txn(2, 8'h5A, 8'hC3, 0, 1, 8'h00, 8'h00);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      txn($urandom_range(0, 2), W'($urandom), W'($urandom),
          $urandom_range(0, 3) == 0, 1, 8'h00, 8'h00);
    end
    idle(5);
    chk("sb_empty", 32'(sb.size()), 0);
    chk("ep_closed", 32'(in_ep), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lab_g_reg_arbiter.md
LAB_G_REG_ARBITER -- requirements
Module: lab_g_reg_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: width of the shared data register and of each requester's data.
REQ-002 Parameter HOLD_CYCLES, default 2, legal range 1..15: number of HOLD cycles after each committed write.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 rst  input  1: reset, asynchronous, active-high.
REQ-005 req0  input  1: requester 0 write request, level-sensitive.
REQ-006 req1  input  1: requester 1 write request, level-sensitive.
REQ-007 d0  input  WIDTH: requester 0 write data.
REQ-008 d1  input  WIDTH: requester 1 write data.
REQ-009 gnt0  output  1: grant to requester 0.
REQ-010 gnt1  output  1: grant to requester 1.
REQ-011 Q  output  WIDTH: shared register (bank of D flip-flops) contents.
REQ-012 owner  output  1: index of the requester whose write last committed to Q.
REQ-013 busy  output  1: high whenever the FSM is not in IDLE.
REQ-014 done  output  1: one-cycle pulse marking the end of a committed transaction.

Function
REQ-015 FSM states SHALL be exactly IDLE, GRANT and HOLD; all outputs SHALL be registered.
REQ-016 IDLE: no requests -> stay in IDLE with gnt0=gnt1=0.
REQ-017 IDLE: exactly one req high -> next edge enters GRANT with the matching gnt high.
REQ-018 IDLE: both req high -> grant the requester other than last_gnt (round-robin); last_gnt is an internal 1-bit register.
REQ-019 GRANT, owner's req still high -> at the next edge: Q <= d of owner, owner <= granted index, last_gnt <= granted index, enter HOLD, HOLD counter <= 1.
REQ-020 GRANT, owner's req low -> abort: no write to Q, owner and last_gnt unchanged, gnt cleared, return to IDLE, done stays 0.
REQ-021 HOLD: grant stays high; the counter increments each cycle; when counter = HOLD_CYCLES, the next edge enters IDLE, clears the grant and asserts done for exactly one cycle.
REQ-022 In HOLD, a change of req or d on either port SHALL have no effect; Q is written only at the GRANT->HOLD edge.
REQ-023 gnt0 and gnt1 SHALL never be high simultaneously.
REQ-024 Latency: request sampled in IDLE at edge n -> grant visible after edge n; Q updated after edge n+1; done high after edge n+1+HOLD_CYCLES. The grant lasts 1+HOLD_CYCLES cycles.
REQ-025 At least one IDLE cycle SHALL separate consecutive grants, including back-to-back grants to the same requester.
REQ-026 busy SHALL equal (state != IDLE).

Reset
REQ-027 When rst is high, the block SHALL immediately force: state=IDLE, gnt0=gnt1=0, Q=0, owner=0, busy=0, done=0, counter=0, last_gnt=1.
REQ-028 With last_gnt=1 after reset, requester 0 SHALL win the first simultaneous request.
REQ-029 rst asserted during GRANT or HOLD SHALL abort the transaction; Q returns to 0 even if a write already committed.
REQ-030 The first IDLE evaluation SHALL occur at the first rising edge after rst falls.

Verification (WIDTH=8, HOLD_CYCLES=2)
REQ-031 Reset, then req0=1 with d0=8'hA5 held -> gnt0 high for 3 cycles, Q=8'hA5 one edge after gnt0 rises, owner=0, done pulses once as gnt0 falls.
REQ-032 req0=req1=1 continuously with d0=8'h11 and d1=8'h22 -> grants alternate 0,1,0,1 with one IDLE cycle between them; Q sequence 11,22,11,22.
REQ-033 req1=1 (d1=8'h3C), req1 dropped during GRANT -> gnt1 clears next edge, Q unchanged, done never asserts, last_gnt unchanged.
REQ-034 d0 changed from 8'h0F to 8'hF0 during HOLD -> Q stays 8'h0F; next transaction writes 8'hF0.
REQ-035 rst pulsed mid-HOLD after Q=8'h77 -> all outputs 0 immediately, without waiting for a clock edge; the following simultaneous request grants requester 0.
REQ-036 All runs: assertion that gnt0&gnt1 is never 1, and that busy matches the state at every cycle.
